// File: rtl/saph_shape_assembler_pkg.sv
// Shared types for the shape assembler: vertex payload, shape type codes,
// batch FSM states and the per-type vertex count.
package saph_shape_assembler_pkg;

  localparam int unsigned COORD_W = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] attr;
  } vertex_t;

  localparam int unsigned VTX_W = $bits(vertex_t);

  typedef enum logic [1:0] {
    SHAPE_LINE = 2'd0,
    SHAPE_TRI  = 2'd1,
    SHAPE_RECT = 2'd2,
    SHAPE_RSVD = 2'd3
  } shape_type_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } batch_state_e;

  // Vertices per primitive; reserved type never forms a primitive.
  function automatic logic [1:0] shape_vtx_count(input shape_type_e t);
    case (t)
      SHAPE_TRI:              return 2'd3;
      SHAPE_LINE, SHAPE_RECT: return 2'd2;
      default:                return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/saph_shape_assembler_outreg.sv
// One-entry shape holding register feeding the rasterizer.
// Ports: load_i/type_i/shape_i load a new shape (takes priority over a
// same-cycle transfer); out_ready_i is the rasterizer ready; trig_o/type_o/
// shape_o are the held shape; xfer_o flags a transfer this cycle.
module saph_shape_assembler_outreg
  import saph_shape_assembler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  shape_type_e       type_i,
  input  vertex_t     [3:0] shape_i,
  input  logic              out_ready_i,
  output logic              trig_o,
  output shape_type_e       type_o,
  output vertex_t     [3:0] shape_o,
  output logic              xfer_o
);

  logic              trig_q, trig_d;
  shape_type_e       type_q, type_d;
  vertex_t     [3:0] shape_q, shape_d;

  assign xfer_o  = trig_q & out_ready_i;
  assign trig_o  = trig_q;
  assign type_o  = type_q;
  assign shape_o = shape_q;

  // Hold until transfer; a load in the transfer cycle keeps trig asserted.
  always_comb begin
    trig_d  = trig_q;
    type_d  = type_q;
    shape_d = shape_q;
    if (xfer_o) trig_d = 1'b0;
    if (load_i) begin
      trig_d  = 1'b1;
      type_d  = type_i;
      shape_d = shape_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q  <= 1'b0;
      type_q  <= SHAPE_LINE;
      shape_q <= '0;
    end else begin
      trig_q  <= trig_d;
      type_q  <= type_d;
      shape_q <= shape_d;
    end
  end

endmodule

// File: rtl/saph_shape_assembler.sv
// Vertex-stream front end: groups vertices into line/tri/rect primitives
// (list or strip) and hands them to the rasterizer through a one-entry
// output register.
// Ports: in_valid/in_ready/in_vtx/in_type/in_strip/in_last vertex input;
// out_trig/out_type/out_shape/out_ready shape output; stat_prims/stat_drop
// wrapping statistics; err_type sticky reserved-type flag.
module saph_shape_assembler
  import saph_shape_assembler_pkg::*;
#(
  parameter bit          enable_strip = 1'b1,
  parameter int unsigned stat_width   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  vertex_t               in_vtx,
  input  logic [1:0]            in_type,
  input  logic                  in_strip,
  input  logic                  in_last,
  output logic                  out_trig,
  output logic [1:0]            out_type,
  output vertex_t [3:0]         out_shape,
  input  logic                  out_ready,
  output logic [stat_width-1:0] stat_prims,
  output logic [stat_width-1:0] stat_drop,
  output logic                  err_type
);

  batch_state_e          state_q, state_d;
  shape_type_e           type_q, type_d;
  logic                  strip_q, strip_d;
  logic [1:0]            count_q, count_d;
  logic                  parity_q, parity_d;
  vertex_t [1:0]         win_q, win_d;
  logic [stat_width-1:0] prims_q, prims_d;
  logic [stat_width-1:0] drop_q, drop_d;
  logic                  err_q, err_d;

  shape_type_e   cur_type_c;
  logic          cur_strip_c;
  logic [1:0]    need_c;
  logic          rsvd_c;
  logic          completes_c;
  logic          accept_c;
  logic          load_c;
  vertex_t [3:0] new_shape_c;
  logic [1:0]    drop_inc_c;
  logic          xfer_c;
  shape_type_e   out_type_e;

  // Type/strip come from the inputs on the first vertex, else from the batch latch.
  assign cur_type_c  = (state_q == ST_IDLE) ? shape_type_e'(in_type) : type_q;
  assign cur_strip_c = ((state_q == ST_IDLE) ? (enable_strip && in_strip) : strip_q)
                       && (cur_type_c != SHAPE_RECT);
  assign need_c      = shape_vtx_count(cur_type_c);
  assign rsvd_c      = (cur_type_c == SHAPE_RSVD);
  assign completes_c = !rsvd_c && (count_q == need_c - 2'd1);

  // Only a completing vertex needs a free output slot.
  assign in_ready = !rst && !(out_trig && !out_ready && completes_c);
  assign accept_c = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    strip_d     = strip_q;
    count_d     = count_q;
    parity_d    = parity_q;
    win_d       = win_q;
    err_d       = err_q;
    load_c      = 1'b0;
    new_shape_c = '0;
    drop_inc_c  = 2'd0;
    if (accept_c) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_COLLECT;
        type_d  = cur_type_c;
        strip_d = cur_strip_c;
      end
      if (rsvd_c) begin
        drop_inc_c = 2'd1;
        err_d      = 1'b1;
      end else if (completes_c) begin
        load_c = 1'b1;
        if (cur_type_c == SHAPE_TRI) begin
          // Odd strip triangles swap the first two slots to keep winding.
          new_shape_c[0] = (cur_strip_c && parity_q) ? win_q[1] : win_q[0];
          new_shape_c[1] = (cur_strip_c && parity_q) ? win_q[0] : win_q[1];
          new_shape_c[2] = in_vtx;
        end else begin
          new_shape_c[0] = win_q[0];
          new_shape_c[1] = in_vtx;
        end
        if (cur_strip_c) begin
          // Slide the window; count stays at k-1 so every vertex completes.
          if (cur_type_c == SHAPE_TRI) begin
            win_d[0] = win_q[1];
            win_d[1] = in_vtx;
            parity_d = !parity_q;
          end else begin
            win_d[0] = in_vtx;
          end
        end else begin
          count_d = 2'd0;
        end
      end else begin
        win_d[count_q[0]] = in_vtx;
        count_d           = count_q + 2'd1;
        if (in_last) drop_inc_c = count_q + 2'd1;
      end
      if (in_last) begin
        state_d  = ST_IDLE;
        count_d  = 2'd0;
        parity_d = 1'b0;
      end
    end
  end

  assign prims_d = prims_q + stat_width'(xfer_c);
  assign drop_d  = drop_q + stat_width'(drop_inc_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      type_q   <= SHAPE_LINE;
      strip_q  <= 1'b0;
      count_q  <= 2'd0;
      parity_q <= 1'b0;
      win_q    <= '0;
      prims_q  <= '0;
      drop_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      strip_q  <= strip_d;
      count_q  <= count_d;
      parity_q <= parity_d;
      win_q    <= win_d;
      prims_q  <= prims_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
    end
  end

  saph_shape_assembler_outreg u_outreg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_c),
    .type_i      (cur_type_c),
    .shape_i     (new_shape_c),
    .out_ready_i (out_ready),
    .trig_o      (out_trig),
    .type_o      (out_type_e),
    .shape_o     (out_shape),
    .xfer_o      (xfer_c)
  );

  assign out_type   = out_type_e;
  assign stat_prims = prims_q;
  assign stat_drop  = drop_q;
  assign err_type   = err_q;

endmodule

// File: tb/tb_saph_shape_assembler.sv
// Directed bench for saph_shape_assembler.
module tb_saph_shape_assembler;
  import saph_shape_assembler_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  vertex_t       in_vtx;
  logic [1:0]    in_type;
  logic          in_strip;
  logic          in_last;
  logic          out_trig;
  logic [1:0]    out_type;
  vertex_t [3:0] out_shape;
  logic          out_ready;
  logic [15:0]   stat_prims;
  logic [15:0]   stat_drop;
  logic          err_type;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]    got_type_q[$];
  vertex_t [3:0] got_shape_q[$];

  always #5 clk = ~clk;

  saph_shape_assembler #(.enable_strip(1'b1), .stat_width(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vtx     (in_vtx),
    .in_type    (in_type),
    .in_strip   (in_strip),
    .in_last    (in_last),
    .out_trig   (out_trig),
    .out_type   (out_type),
    .out_shape  (out_shape),
    .out_ready  (out_ready),
    .stat_prims (stat_prims),
    .stat_drop  (stat_drop),
    .err_type   (err_type)
  );

  // Record every shape that will transfer on the coming edge.
  always @(negedge clk) begin
    if (!rst && out_trig && out_ready) begin
      got_type_q.push_back(out_type);
      got_shape_q.push_back(out_shape);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic vertex_t mkv(input int n);
    vertex_t v;
    v.x    = 16'(n);
    v.y    = 16'(n * 3 + 7);
    v.attr = 16'(n ^ 16'h5a5a);
    return v;
  endfunction

  task automatic send(input vertex_t v, input logic [1:0] t, input logic s, input logic last);
    int k;
    in_vtx   = v;
    in_type  = t;
    in_strip = s;
    in_last  = last;
    in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 50) check_eq("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_shape(input string tag, input logic [1:0] t, input vertex_t s0,
                              input vertex_t s1, input vertex_t s2, input vertex_t s3);
    logic [1:0]    gt;
    vertex_t [3:0] gs;
    if (got_type_q.size() == 0) begin
      check_eq({tag, "_missing"}, 64'd0, 64'd1);
    end else begin
      gt = got_type_q.pop_front();
      gs = got_shape_q.pop_front();
      check_eq({tag, "_type"}, 64'(gt), 64'(t));
      check_eq({tag, "_s0"}, 64'(gs[0]), 64'(s0));
      check_eq({tag, "_s1"}, 64'(gs[1]), 64'(s1));
      check_eq({tag, "_s2"}, 64'(gs[2]), 64'(s2));
      check_eq({tag, "_s3"}, 64'(gs[3]), 64'(s3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vertex_t z, a, b, c, d, e, f, p, q, r, s, x, y;
    z = '0;
    a = mkv(1); b = mkv(2); c = mkv(3); d = mkv(4); e = mkv(5); f = mkv(6);
    p = mkv(16); q = mkv(17); r = mkv(18); s = mkv(19); x = mkv(24); y = mkv(25);

    rst = 1'b1; in_valid = 1'b0; in_vtx = '0; in_type = 2'd0;
    in_strip = 1'b0; in_last = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_trig", 64'(out_trig), 64'd0);
    check_eq("rst_prims", 64'(stat_prims), 64'd0);
    check_eq("rst_drop", 64'(stat_drop), 64'd0);
    check_eq("rst_err", 64'(err_type), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("post_rst_type", 64'(out_type), 64'd0);
    check_eq("post_rst_shape", 64'(out_shape[0]), 64'd0);
    @(posedge clk); #1;

    // TRI list A..F, latency 1 after C and F
    send(a, 2'd1, 1'b0, 1'b0);
    send(b, 2'd1, 1'b0, 1'b0);
    check_eq("tri_pre_trig", 64'(out_trig), 64'd0);
    send(c, 2'd1, 1'b0, 1'b0);
    check_eq("tri_lat_c", 64'(out_trig), 64'd1);
    send(d, 2'd1, 1'b0, 1'b0);
    send(e, 2'd1, 1'b0, 1'b0);
    send(f, 2'd1, 1'b0, 1'b1);
    check_eq("tri_lat_f", 64'(out_trig), 64'd1);
    idle(3);
    expect_shape("tri_list0", 2'd1, a, b, c, z);
    expect_shape("tri_list1", 2'd1, d, e, f, z);
    check_eq("tri_list_prims", 64'(stat_prims), 64'd2);

    // TRI strip A..E
    send(a, 2'd1, 1'b1, 1'b0);
    send(b, 2'd1, 1'b1, 1'b0);
    send(c, 2'd1, 1'b1, 1'b0);
    send(d, 2'd1, 1'b1, 1'b0);
    send(e, 2'd1, 1'b1, 1'b1);
    idle(3);
    expect_shape("tri_strip0", 2'd1, a, b, c, z);
    expect_shape("tri_strip1", 2'd1, c, b, d, z);
    expect_shape("tri_strip2", 2'd1, c, d, e, z);
    check_eq("tri_strip_prims", 64'(stat_prims), 64'd5);

    // LINE list with rasterizer back-pressure
    out_ready = 1'b0;
    send(a, 2'd0, 1'b0, 1'b0);
    send(b, 2'd0, 1'b0, 1'b0);
    check_eq("bp_trig", 64'(out_trig), 64'd1);
    send(c, 2'd0, 1'b0, 1'b0);
    in_vtx = d; in_type = 2'd0; in_strip = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_hold_s0", 64'(out_shape[0]), 64'(a));
      check_eq("bp_hold_s1", 64'(out_shape[1]), 64'(b));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check_eq("bp_reload_trig", 64'(out_trig), 64'd1);
    idle(3);
    expect_shape("bp_line0", 2'd0, a, b, z, z);
    expect_shape("bp_line1", 2'd0, c, d, z, z);
    check_eq("bp_prims", 64'(stat_prims), 64'd7);

    // RECT with strip requested behaves as list
    send(p, 2'd2, 1'b1, 1'b0);
    send(q, 2'd2, 1'b1, 1'b0);
    send(r, 2'd2, 1'b1, 1'b0);
    send(s, 2'd2, 1'b1, 1'b1);
    idle(3);
    expect_shape("rect0", 2'd2, p, q, z, z);
    expect_shape("rect1", 2'd2, r, s, z, z);
    check_eq("rect_no_extra", 64'(got_type_q.size()), 64'd0);

    // Partial TRI discarded on in_last
    send(a, 2'd1, 1'b0, 1'b0);
    send(b, 2'd1, 1'b0, 1'b1);
    idle(3);
    check_eq("partial_none", 64'(got_type_q.size()), 64'd0);
    check_eq("partial_drop", 64'(stat_drop), 64'd2);
    check_eq("partial_prims", 64'(stat_prims), 64'd9);

    // Reserved type
    send(a, 2'd3, 1'b0, 1'b0);
    send(b, 2'd3, 1'b0, 1'b1);
    idle(3);
    check_eq("rsvd_none", 64'(got_type_q.size()), 64'd0);
    check_eq("rsvd_drop", 64'(stat_drop), 64'd4);
    check_eq("rsvd_err", 64'(err_type), 64'd1);
    send(x, 2'd0, 1'b0, 1'b0);
    send(y, 2'd0, 1'b0, 1'b1);
    idle(3);
    expect_shape("after_rsvd", 2'd0, x, y, z, z);
    check_eq("rsvd_err_sticky", 64'(err_type), 64'd1);
    check_eq("after_rsvd_prims", 64'(stat_prims), 64'd10);

    // Async reset mid-batch with a held shape
    out_ready = 1'b0;
    send(a, 2'd1, 1'b0, 1'b0);
    send(b, 2'd1, 1'b0, 1'b0);
    send(c, 2'd1, 1'b0, 1'b0);
    send(d, 2'd1, 1'b0, 1'b0);
    check_eq("mid_trig", 64'(out_trig), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_trig", 64'(out_trig), 64'd0);
    check_eq("mid_rst_ready", 64'(in_ready), 64'd0);
    check_eq("mid_rst_prims", 64'(stat_prims), 64'd0);
    check_eq("mid_rst_drop", 64'(stat_drop), 64'd0);
    check_eq("mid_rst_err", 64'(err_type), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    got_type_q.delete();
    got_shape_q.delete();
    send(x, 2'd0, 1'b0, 1'b0);
    send(y, 2'd0, 1'b0, 1'b1);
    idle(3);
    expect_shape("post_mid_rst", 2'd0, x, y, z, z);
    check_eq("post_mid_rst_prims", 64'(stat_prims), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
